// File: rtl/vga_scanout_pkg.sv
// Shared VGA definitions: 3-bit {R,G,B} colour codes, default 640x480@60 timing
// and small helpers used by the scanout block and its timing counter.
package vga_scanout_pkg;

  localparam int unsigned CntW = 12;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned WIN_W = 512;
  localparam int unsigned WIN_H = 256;

  // True when x lies in the half-open interval [lo, lo+len).
  function automatic logic in_range(logic [CntW-1:0] x, int unsigned lo, int unsigned len);
    return (x >= CntW'(lo)) && (x < CntW'(lo + len));
  endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Raster position counters: hcnt wraps every H_TOTAL enabled cycles and steps vcnt,
// which wraps every V_TOTAL lines.
module vga_timing_counter
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [CntW-1:0] hcnt_o,
  output logic [CntW-1:0] vcnt_o
);

  logic [CntW-1:0] hcnt_q, hcnt_d;
  logic [CntW-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (en_i) begin
      if (hcnt_q == CntW'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == CntW'(V_TOTAL - 1)) ? '0 : vcnt_q + CntW'(1);
      end else begin
        hcnt_d = hcnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o = hcnt_q;
  assign vcnt_o = vcnt_q;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: timing counters feed a two-stage pipeline (address/flags, then
// colour/sync) so colour, sync and frame-start leave mutually aligned.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iPixelEnable,
  output logic [16:0] oReadAddress,
  input  logic [2:0]  iReadData,
  output logic        oRed,
  output logic        oGreen,
  output logic        oBlue,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oFrameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  logic [CntW-1:0] hcnt, vcnt;

  vga_timing_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL)
  ) u_timing (
    .clk_i (Clock),
    .rst_i (Reset),
    .en_i  (iPixelEnable),
    .hcnt_o(hcnt),
    .vcnt_o(vcnt)
  );

  // Stage 1: read address and per-pixel flags.
  logic [16:0] addr_q, addr_d;
  logic        win_q, win_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        frame_q, frame_d;

  // Stage 2: registered DAC/sync outputs; syncs are active-low.
  logic [2:0]  rgb_q, rgb_d;
  logic        hsync_n_q, hsync_n_d;
  logic        vsync_n_q, vsync_n_d;
  logic        fstart_q, fstart_d;

  always_comb begin
    addr_d    = {vcnt[7:0], hcnt[8:0]};
    win_d     = (hcnt < CntW'(WIN_W)) && (vcnt < CntW'(WIN_H));
    hs_d      = in_range(hcnt, H_VISIBLE + H_FRONT, H_SYNC);
    vs_d      = in_range(vcnt, V_VISIBLE + V_FRONT, V_SYNC);
    frame_d   = (hcnt == '0) && (vcnt == '0);
    // Read data belongs to addr_q, so it is gated by the matching stage-1 flag.
    rgb_d     = win_q ? iReadData : COLOR_BLACK;
    hsync_n_d = ~hs_q;
    vsync_n_d = ~vs_q;
    fstart_d  = frame_q;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_q    <= '0;
      win_q     <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      frame_q   <= 1'b0;
      rgb_q     <= COLOR_BLACK;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      fstart_q  <= 1'b0;
    end else if (iPixelEnable) begin
      addr_q    <= addr_d;
      win_q     <= win_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      frame_q   <= frame_d;
      rgb_q     <= rgb_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      fstart_q  <= fstart_d;
    end
  end

  assign oReadAddress = addr_q;
  assign oRed         = rgb_q[2];
  assign oGreen       = rgb_q[1];
  assign oBlue        = rgb_q[0];
  assign oHSync       = hsync_n_q;
  assign oVSync       = vsync_n_q;
  assign oFrameStart  = fstart_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a default-timing instance and a short-frame instance share
// stimulus; a raster-position model predicts every output on every cycle.
module tb_vga_scanout;

  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int BHV = 12,  BHF = 2,  BHS = 3,  BHB = 3;
  localparam int BVV = 260, BVF = 4,  BVS = 2,  BVB = 4;
  localparam int AHT = AHV + AHF + AHS + AHB;
  localparam int AVT = AVV + AVF + AVS + AVB;
  localparam int BHT = BHV + BHF + BHS + BHB;
  localparam int BVT = BVV + BVF + BVS + BVB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic [16:0] addr_a, addr_b;
  logic [2:0]  rd_a, rd_b;
  logic        r_a, g_a, b_a, hs_a, vs_a, fs_a;
  logic        r_b, g_b, b_b, hs_b, vs_b, fs_b;

  // Framebuffer model: pixel colour equals the low three address bits.
  assign rd_a = addr_a[2:0];
  assign rd_b = addr_b[2:0];

  vga_scanout u_dut_a (
    .Clock(clk), .Reset(rst), .iPixelEnable(en), .oReadAddress(addr_a), .iReadData(rd_a),
    .oRed(r_a), .oGreen(g_a), .oBlue(b_a), .oHSync(hs_a), .oVSync(vs_a), .oFrameStart(fs_a)
  );

  vga_scanout #(
    .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
    .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
  ) u_dut_b (
    .Clock(clk), .Reset(rst), .iPixelEnable(en), .oReadAddress(addr_b), .iReadData(rd_b),
    .oRed(r_b), .oGreen(g_b), .oBlue(b_b), .oHSync(hs_b), .oVSync(vs_b), .oFrameStart(fs_b)
  );

  int checks   = 0;
  int failures = 0;
  int printed  = 0;
  int n        = -1;  // enabled edges since the last reset edge; -1 before any reset

  always @(posedge clk) begin
    if (rst) n <= 0;
    else if (en && n >= 0) n <= n + 1;
  end

  function automatic logic [16:0] addr_at(int pos, int ht, int vt);
    logic [31:0] h, v;
    h = pos % ht;
    v = (pos / ht) % vt;
    return {v[7:0], h[8:0]};
  endfunction

  // Outputs after k enabled edges: address shows raster position k-1, the colour/sync
  // stage shows position k-2, anything earlier shows reset values.
  function automatic logic [22:0] model(int k, int hv, int hf, int hs, int vv, int vf,
                                        int vs, int ht, int vt);
    logic [16:0] a, pa;
    logic [2:0]  rgb;
    logic        hsn, vsn, fs;
    int          pos, h, v;
    a   = (k == 0) ? 17'd0 : addr_at(k - 1, ht, vt);
    rgb = 3'b000;
    hsn = 1'b1;
    vsn = 1'b1;
    fs  = 1'b0;
    if (k >= 2) begin
      pos = k - 2;
      h   = pos % ht;
      v   = (pos / ht) % vt;
      pa  = addr_at(pos, ht, vt);
      rgb = (h < 512 && v < 256) ? pa[2:0] : 3'b000;
      hsn = !(h >= hv + hf && h < hv + hf + hs);
      vsn = !(v >= vv + vf && v < vv + vf + vs);
      fs  = (h == 0 && v == 0);
    end
    return {a, rgb, hsn, vsn, fs};
  endfunction

  always @(negedge clk) begin
    logic [22:0] got, exp;
    if (n >= 0) begin
      got = {addr_a, r_a, g_a, b_a, hs_a, vs_a, fs_a};
      exp = model(n, AHV, AHF, AHS, AVV, AVF, AVS, AHT, AVT);
      checks++;
      if (got !== exp) begin
        failures++;
        if (printed < 20) begin
          printed++;
          $display("FAIL model_a n=%0d got=%h expected=%h", n, got, exp);
        end
      end
      got = {addr_b, r_b, g_b, b_b, hs_b, vs_b, fs_b};
      exp = model(n, BHV, BHF, BHS, BVV, BVF, BVS, BHT, BVT);
      checks++;
      if (got !== exp) begin
        failures++;
        if (printed < 20) begin
          printed++;
          $display("FAIL model_b n=%0d got=%h expected=%h", n, got, exp);
        end
      end
    end
  end

  task automatic cyc(input logic e, input logic r);
    en  = e;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  initial begin
    // Reset with enable low and high: reset wins either way.
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    chk("reset_addr", int'(addr_a), 0);
    chk("reset_rgb", int'({r_a, g_a, b_a}), 0);
    chk("reset_hsync", int'(hs_a), 1);
    chk("reset_vsync", int'(vs_a), 1);
    chk("reset_fstart", int'(fs_a), 0);

    // Continuous enable from reset release; c counts enabled edges.
    for (int c = 1; c <= 5410; c++) begin
      cyc(1'b1, 1'b0);
      case (c)
        1:    chk("fs_c1", int'(fs_a), 0);
        2:    begin chk("fs_c2", int'(fs_a), 1); chk("addr_c2", int'(addr_a), 1); end
        3:    chk("fs_c3", int'(fs_a), 0);
        657:  chk("hs_pre", int'(hs_a), 1);
        658:  chk("hs_first_low", int'(hs_a), 0);
        753:  chk("hs_last_low", int'(hs_a), 0);
        754:  chk("hs_post", int'(hs_a), 1);
        2407: chk("pix_r3_c5", int'({r_a, g_a, b_a}), 5);
        3002: chk("pix_r3_c600", int'({r_a, g_a, b_a}), 0);
        5107: chk("b_pix_r255_c5", int'({r_b, g_b, b_b}), 5);
        5167: chk("b_pix_r258_c5", int'({r_b, g_b, b_b}), 0);
        5281: chk("b_vs_pre", int'(vs_b), 1);
        5282: chk("b_vs_first_low", int'(vs_b), 0);
        5321: chk("b_vs_last_low", int'(vs_b), 0);
        5322: chk("b_vs_post", int'(vs_b), 1);
        5400: chk("b_addr_last", int'(addr_b), 6675);
        5401: begin chk("b_addr_wrap", int'(addr_b), 0); chk("b_fs_pre", int'(fs_b), 0); end
        5402: chk("b_fs_period", int'(fs_b), 1);
        default: ;
      endcase
    end

    // Half-rate enable: pipeline holds on disabled cycles.
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    chk("toggle_fs_on", int'(fs_a), 1);
    cyc(1'b0, 1'b0);
    chk("toggle_fs_hold", int'(fs_a), 1);
    cyc(1'b1, 1'b0);
    chk("toggle_fs_off", int'(fs_a), 0);
    for (int i = 0; i < 3200; i++) cyc(1'(i % 2 == 0), 1'b0);

    // Mid-frame reset, then restart from (0,0).
    cyc(1'b1, 1'b1);
    for (int c = 0; c < 4400; c++) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    chk("midreset_addr_a", int'(addr_a), 0);
    chk("midreset_addr_b", int'(addr_b), 0);
    cyc(1'b1, 1'b0);
    chk("midreset_fs_1", int'(fs_a), 0);
    cyc(1'b1, 1'b0);
    chk("midreset_fs_a", int'(fs_a), 1);
    chk("midreset_fs_b", int'(fs_b), 1);

    // Random enable with occasional reset pulses.
    for (int i = 0; i < 20000; i++) cyc(1'($urandom_range(3, 0) != 0),
                                        1'($urandom_range(2999, 0) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameters V_VISIBLE / V_FRONT / V_SYNC / V_BACK, defaults 480 / 10 / 2 / 33, in lines.
REQ-006 Clock  input  1  single system clock; all logic on its rising edge.
REQ-007 Reset  input  1  synchronous, active-high reset.
REQ-008 iPixelEnable  input  1  pixel-rate strobe; the pipeline advances only on cycles where it is 1.
REQ-009 oReadAddress  output  17  framebuffer read address, {row[7:0], col[8:0]}.
REQ-010 iReadData  input  3  framebuffer pixel {R,G,B}, valid one enabled cycle after oReadAddress.
REQ-011 oRed, oGreen, oBlue  output  1 each  pixel colour to the DAC.
REQ-012 oHSync, oVSync  output  1 each  sync outputs, active-low.
REQ-013 oFrameStart  output  1  one-enabled-cycle pulse aligned with output pixel (0,0).

Function
REQ-014 Horizontal counter hcnt SHALL count 0..H_TOTAL-1 and then wrap to 0, where H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 800).
REQ-015 Vertical counter vcnt SHALL increment only when hcnt wraps, count 0..V_TOTAL-1, and then wrap to 0 (default V_TOTAL 525).
REQ-016 Counters and all pipeline registers SHALL hold their value on cycles where iPixelEnable=0.
REQ-017 Stage 1 SHALL register the following from the stage-0 counters:
- oReadAddress = {vcnt[7:0], hcnt[8:0]};
- window flag = (hcnt<512)&&(vcnt<256);
- hsync flag = (hcnt in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]);
- vsync flag = (vcnt in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]);
- frame flag = (hcnt==0 && vcnt==0).
REQ-018 Stage 2 SHALL register the outputs:
- {oRed,oGreen,oBlue} = window flag ? iReadData : 3'b000;
- oHSync = ~hsync flag; oVSync = ~vsync flag;
- oFrameStart = frame flag.
REQ-019 Colour, sync and frame-start outputs SHALL lag the counters by exactly 2 enabled cycles, so that all outputs are mutually aligned.
REQ-020 Pixels outside the 512x256 window, including all porch and sync intervals, SHALL output black.
REQ-021 oReadAddress SHALL still update outside the window; downstream logic SHALL ignore iReadData there.
REQ-022 At the end of the frame (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1), both counters SHALL return to 0 on the same enabled cycle.

Reset
REQ-023 While Reset=1, on each rising edge:
- hcnt=0, vcnt=0;
- oReadAddress=0;
- pipeline flags cleared;
- RGB=000;
- oHSync=1, oVSync=1;
- oFrameStart=0.
REQ-024 Reset SHALL take priority over iPixelEnable.
REQ-025 Reset asserted mid-frame SHALL abandon the frame in progress; scanning restarts at (0,0) on the first enabled cycle after release.
REQ-026 The first oFrameStart after reset SHALL occur 2 enabled cycles after release.

Structure
REQ-027 The 3-bit colour codes (COLOR_BLACK, COLOR_YELLOW, ...) and the default 640x480@60 timing constants SHALL reside in the shared definitions header used by the CPU and ROM.
REQ-028 One sub-module vga_timing_counter SHALL hold hcnt/vcnt and wrap logic; the address/colour pipeline SHALL live in vga_scanout.
REQ-029 The framebuffer RAM SHALL be external to this block.

Verification
REQ-030 Reset, then iPixelEnable=1 continuously -> oHSync low exactly 96 cycles per 800-cycle line, low phase starting 656+2 cycles after line start.
REQ-031 Free-run -> oVSync low for exactly 2 lines (1600 enabled cycles) per 420000-cycle frame; oFrameStart period exactly 420000.
REQ-032 Model RAM returning iReadData=address[2:0] -> output pixel (row 3, col 5) is 3'b101; pixel (row 3, col 600) is 000; pixel (row 300, col 5) is 000.
REQ-033 iPixelEnable toggling 1,0,1,0 -> line period 1600 clocks; outputs identical to the continuous run when sampled on enabled cycles.
REQ-034 Reset asserted at hcnt=400, vcnt=200 for 1 cycle -> next oReadAddress=0; oFrameStart pulses 2 enabled cycles after release.
REQ-035 Last pixel of frame (hcnt=799, vcnt=524) -> next counter state is (0,0); oReadAddress wraps to 17'd0 one enabled cycle later.
